// File: rtl/sine_rom_arbiter_if.sv
// Bus bundle for sine_rom_arbiter: requester handshake, external ROM port and
// tagged result. slave = arbiter side, master = requesters/ROM/consumer side.
interface sine_rom_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ*(ADDR_WIDTH+2)-1:0] phase;
  logic [NUM_REQ-1:0]                ack;
  logic [ADDR_WIDTH-1:0]             rom_addr;
  logic [DATA_WIDTH-1:0]             rom_q;
  logic                              out_valid;
  logic [TAG_WIDTH-1:0]              out_tag;
  logic [DATA_WIDTH:0]               out_data;

  modport slave (
    input  req, phase, rom_q,
    output ack, rom_addr, out_valid, out_tag, out_data
  );

  modport master (
    output req, phase, rom_q,
    input  ack, rom_addr, out_valid, out_tag, out_data
  );
endinterface

// File: rtl/sine_rom_arbiter.sv
// Shares one external quarter-wave sine ROM between NUM_REQ requesters via a
// 3-stage pipeline. Define SINE_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module sine_rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               reset_reg_N,
  sine_rom_arbiter_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 2;

  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic                  s1_neg_q, s1_neg_d, s2_neg_q, s2_neg_d;
  logic                  out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic [DATA_WIDTH:0]   out_data_q, out_data_d;
`ifndef SINE_ARB_FIXED_PRIO_EN
  logic [TAG_WIDTH-1:0]  last_q, last_d;
  logic [TAG_WIDTH:0]    cand;
`endif

  logic [PW-1:0]         ph [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic                  found;
  logic [TAG_WIDTH-1:0]  win;
  logic [PW-1:0]         sel_phase;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH:0]   mag;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ph[g] = bus.phase[g*PW +: PW];
  end

  always_comb begin
    // Masking by the visible ack stops a still-held level from winning twice.
    elig  = bus.req & ~ack_q;
    found = 1'b0;
    win   = '0;
`ifdef SINE_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && elig[TAG_WIDTH'(i)]) begin
        found = 1'b1;
        win   = TAG_WIDTH'(i);
      end
    end
`else
    cand = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (TAG_WIDTH+1)'(k);
      if (cand >= (TAG_WIDTH+1)'(NUM_REQ)) cand = cand - (TAG_WIDTH+1)'(NUM_REQ);
      if (!found && elig[cand[TAG_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = cand[TAG_WIDTH-1:0];
      end
    end
`endif
    sel_phase = ph[win];
    idx       = sel_phase[ADDR_WIDTH-1:0];
    mag       = {1'b0, bus.rom_q};
  end

  always_comb begin
    ack_d      = found ? (NUM_REQ'(1) << win) : '0;
    rom_addr_d = rom_addr_q;
    s1_tag_d   = s1_tag_q;
    s1_neg_d   = s1_neg_q;
    if (found) begin
      // Odd quadrants mirror the index, upper half-wave is negated.
      rom_addr_d = sel_phase[ADDR_WIDTH] ? ~idx : idx;
      s1_tag_d   = win;
      s1_neg_d   = sel_phase[ADDR_WIDTH+1];
    end
    s1_valid_d  = found;
    s2_valid_d  = s1_valid_q;
    s2_tag_d    = s1_tag_q;
    s2_neg_d    = s1_neg_q;
    out_valid_d = s2_valid_q;
    out_tag_d   = s2_valid_q ? s2_tag_q : out_tag_q;
    out_data_d  = out_data_q;
    if (s2_valid_q) out_data_d = s2_neg_q ? ('0 - mag) : mag;
`ifndef SINE_ARB_FIXED_PRIO_EN
    last_d = found ? win : last_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_reg_N) begin
      ack_q       <= '0;
      rom_addr_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_neg_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      s2_neg_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
`ifndef SINE_ARB_FIXED_PRIO_EN
      last_q      <= TAG_WIDTH'(NUM_REQ - 1);
`endif
    end else begin
      ack_q       <= ack_d;
      rom_addr_q  <= rom_addr_d;
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s1_neg_q    <= s1_neg_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      s2_neg_q    <= s2_neg_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
`ifndef SINE_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: doc/sine_rom_arbiter.md
# sine_rom_arbiter

Round-robin arbiter and sequencer that shares one 512×16 quarter-wave sine ROM between several requesters, typically oscillator voices in the synth engine. Each requester presents an 11-bit phase (2-bit quadrant + 9-bit index). The block folds the phase onto the quarter table, drives the ROM address and applies quadrant sign. It returns a signed full-wave sample tagged with the requester number. The ROM stays external, with a registered one-cycle read latency; this block owns its address bus.

## Interface

- `NUM_REQ`, 4: number of requesters, 2..16.
- `ADDR_WIDTH`, 9: ROM address width. Phase width is `ADDR_WIDTH+2`.
- `DATA_WIDTH`, 16: ROM word width, unsigned magnitude.
- `TAG_WIDTH`, `$clog2(NUM_REQ)`: width of `out_tag`.

Ports:

- `clk` in 1: single clock. Every register updates on its rising edge.
- `reset_reg_N` in 1: synchronous, active-low reset. It is sampled only on `clk` rising edge.
- `req` in NUM_REQ: per-requester request level.
- `phase` in NUM_REQ*(ADDR_WIDTH+2): packed phases. Requester i occupies bits `[i*(ADDR_WIDTH+2) +: ADDR_WIDTH+2]`.
- `ack` out NUM_REQ: one-hot, one-cycle grant acknowledge.
- `rom_addr` out ADDR_WIDTH: registered ROM address.
- `rom_q` in DATA_WIDTH: ROM data, valid one cycle after `rom_addr`.
- `out_valid` out 1: result strobe.
- `out_tag` out TAG_WIDTH: requester index of the result.
- `out_data` out DATA_WIDTH+1: signed two's-complement sine sample.

## Operation

- **Phase fields:** quadrant `qd = phase_i[ADDR_WIDTH+1:ADDR_WIDTH]`, index `idx = phase_i[ADDR_WIDTH-1:0]`.
- **Fold by quadrant:**
  - qd=0: address `idx`, positive.
  - qd=1: address `~idx` (that is, 511−idx), positive.
  - qd=2: address `idx`, negative.
  - qd=3: address `~idx`, negative.
- **Eligible requesters:** `req & ~ack`. A requester whose `ack` is high this cycle is masked, so a level still held while its ack is visible is never granted twice.
- **Grant rule:** among eligible requesters, grant the first one at or after `last+1`, wrapping modulo NUM_REQ. `last` updates to the winner.
  - `last` resets to NUM_REQ−1, so requester 0 wins first after reset.
  - No eligible requester: no grant, `last` unchanged.
- **Requester handshake:**
  - Hold `req` and `phase` stable until `ack` is seen.
  - Keeping `req` high in the cycle after `ack` constitutes a new request. It becomes eligible the cycle after that.
- **Pipeline** (three stages, no internal state machine beyond `last`):
  - **S0, arbitrate:** on the edge, load `rom_addr` with the folded address, pulse `ack[winner]`, and register `s1_valid`, `s1_tag` and `s1_neg`.
  - **S1, ROM read:** the ROM registers `rom_q`. The block delays `s1_valid`, `s1_tag` and `s1_neg` one stage.
  - **S2, sign:** on the edge, `out_data` = neg ? −{1'b0,rom_q} : {1'b0,rom_q}. `out_valid` and `out_tag` load from stage 2.
- **Arithmetic:**
  - Output width DATA_WIDTH+1 holds ±65535 without overflow.
  - Negating 0 yields 0.
- **No backpressure:** the consumer must accept every `out_valid` cycle.
- **Idle and hold behaviour:**
  - When no grant occurs, `rom_addr` holds its previous value.
  - `out_data` and `out_tag` hold their last value while `out_valid`=0.

## Timing

- **Reset values** (reset_reg_N=0 at an edge): `ack`=0, `rom_addr`=0, `out_valid`=0, `out_tag`=0, `out_data`=0, all stage valids 0, `last`=NUM_REQ−1.
- **Reset mid-operation:** in-flight results are discarded and no `out_valid` follows them. Requests are sampled again on the first edge with reset_reg_N=1.
- **Latency:** with `req` sampled at edge E:
  - `ack` and `rom_addr` are valid after E.
  - `rom_q` is valid after E+1.
  - `out_valid` is valid after E+2.
  - Result appears 3 edges after the request is first presented with the arbiter free.
- **Throughput:** one grant per cycle. NUM_REQ simultaneous requests produce NUM_REQ consecutive `out_valid` cycles.
- **Back-to-back requests:** a single requester holding `req` continuously is granted every other cycle (ack masking).

## Configuration

- `SINE_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest-index eligible requester always wins, `last` is not implemented, and the ack masking rule still applies.
- Undefined (default): round-robin as described above.

## Test plan

- **Single-request quadrant folding:** requester 0 alone, phase 0x005 then 0x205, 0x405, 0x605.
  - `rom_addr` = 5, 506, 5, 506.
  - Given rom_q=1000: `out_data` = +1000, +1000, −1000, −1000, each 3 edges after its request, `out_tag`=0.
- **Fold boundaries:** qd=1 with idx=0 → `rom_addr`=511; qd=1 with idx=511 → `rom_addr`=0; qd=2 with rom_q=0 → `out_data`=0.
- **Simultaneous requests:** all 4 requesters assert in the same cycle and drop after their ack.
  - `ack` order is 0,1,2,3 on consecutive cycles.
  - `out_tag` = 0,1,2,3 on 4 consecutive `out_valid` cycles.
- **Round-robin fairness:** requesters 1 and 3 hold `req` continuously.
  - Grants alternate 1,3,1,3.
  - No requester is granted in two consecutive cycles.
- **Reset mid-flight:** assert reset_reg_N=0 for one edge, one cycle after a grant.
  - No `out_valid` follows for the discarded request.
  - All outputs read 0.
  - The next grant goes to the lowest requesting index.
- **Fixed-priority build** (`SINE_ARB_FIXED_PRIO_EN` defined): requesters 0 and 2 hold `req`.
  - Grants follow 0,2,0,2 because of ack masking.
  - Requester 2 is never granted while requester 0 is eligible.
